cajero_ctrl: RTL and testbench

ATM transaction controller: the responder side of the card/PIN/amount stimulus interface driven by the bench. It collects a 4-digit BCD PIN one strobe at a time and checks it against the stored PIN. It then executes one deposit or withdrawal on a 64-bit balance and reports the result with single-cycle pulses. After the configured number of wrong PIN attempts it locks the machine until reset.

---
 rtl/cajero_ctrl_pkg.sv | 20 ++
 rtl/cajero_ctrl_detector_flanco.sv | 24 ++
 rtl/cajero_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_cajero_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cajero_ctrl_pkg.sv
// Shared definitions for the ATM controller: data widths, FSM state
// encoding and transaction-type codes.
package cajero_ctrl_pkg;

    localparam int ANCHO_BALANCE = 64;
    localparam int ANCHO_MONTO   = 32;
    localparam int ANCHO_PIN     = 16;

    typedef enum logic [2:0] {
        ST_ESPERA_TARJETA = 3'd0,
        ST_ESPERA_PIN     = 3'd1,
        ST_ESPERA_MONTO   = 3'd2,
        ST_TRANSACCION    = 3'd3,
        ST_BLOQUEO        = 3'd4
    } estado_t;

    localparam logic TIPO_DEPOSITO = 1'b0;
    localparam logic TIPO_RETIRO   = 1'b1;

endpackage

// File: rtl/cajero_ctrl_detector_flanco.sv
// detector_flanco: 1-bit rising-edge detector. The output is high in the
// cycle where the input is 1 and was 0 at the previous clock edge.
module detector_flanco (
    input  logic clk,
    input  logic rst,
    input  logic senal,
    output logic flanco
);

    logic previo;

    // Remember the input value seen at the previous edge.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state always uses <= so every flop samples pre-edge values.
        if (rst) begin
            previo <= 1'b0;
        end else begin
            previo <= senal;
        end
    end

    assign flanco = senal & ~previo;

endmodule

// File: rtl/cajero_ctrl.sv
// cajero_ctrl: ATM transaction controller. Collects a 4-digit BCD PIN,
// locks after MAX_INTENTOS wrong attempts, then runs one deposit or
// withdrawal on a 64-bit balance and reports it with 1-cycle pulses.
// Optional macro BALANCE_SAT_EN: deposits saturate at 2^64-1 instead of
// wrapping modulo 2^64.
module cajero_ctrl
    import cajero_ctrl_pkg::*;
#(
    parameter int MAX_INTENTOS = 3
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     TARJETA_RECIBIDA,
    input  logic                     DIGITO_STB,
    input  logic [3:0]               DIGITO,
    input  logic [ANCHO_PIN-1:0]     PIN_CORRECTO,
    input  logic [ANCHO_BALANCE-1:0] BALANCE_INICIAL,
    input  logic                     TIPO_TRANS,
    input  logic                     MONTO_STB,
    input  logic [ANCHO_MONTO-1:0]   MONTO,
    output logic [ANCHO_BALANCE-1:0] BALANCE,
    output logic                     BALANCE_ACTUALIZADO,
    output logic                     ENTREGAR_DINERO,
    output logic                     FONDOS_INSUFICIENTES,
    output logic                     PIN_INCORRECTO,
    output logic                     ADVERTENCIA,
    output logic                     BLOQUEO
);

    localparam logic [2:0] MAX_I = 3'(MAX_INTENTOS);

    estado_t estado, estado_sig;
    // Only the three older digits are kept; the 4th is compared straight
    // from the DIGITO input on its strobe edge.
    logic [11:0]              pin_reg, pin_reg_sig;
    logic [1:0]               cuenta, cuenta_sig;
    logic [2:0]               intentos, intentos_sig, intentos_nuevo;
    logic [ANCHO_MONTO-1:0]   monto_reg, monto_sig;
    logic                     tipo_reg, tipo_sig;
    logic [ANCHO_BALANCE-1:0] balance, balance_sig;
    logic [ANCHO_BALANCE-1:0] monto_ext, suma_deposito;
    logic                     cargado, cargado_sig;
    logic                     advertencia, adv_sig;
    logic                     act, act_sig, entregar, ent_sig;
    logic                     fondos, fondos_sig, pin_inc, inc_sig;
    logic                     digito_flanco, monto_flanco;

    detector_flanco u_flanco_digito (
        .clk   (CLK),
        .rst   (RESET),
        .senal (DIGITO_STB),
        .flanco(digito_flanco)
    );

    detector_flanco u_flanco_monto (
        .clk   (CLK),
        .rst   (RESET),
        .senal (MONTO_STB),
        .flanco(monto_flanco)
    );

    assign monto_ext = {{(ANCHO_BALANCE-ANCHO_MONTO){1'b0}}, monto_reg};

`ifdef BALANCE_SAT_EN
    logic [ANCHO_BALANCE:0] suma_ancha;
    assign suma_ancha    = {1'b0, balance} + {1'b0, monto_ext};
    assign suma_deposito = suma_ancha[ANCHO_BALANCE] ? '1 : suma_ancha[ANCHO_BALANCE-1:0];
`else
    assign suma_deposito = balance + monto_ext;
`endif

    // Next-state and next-output logic for the whole session.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        estado_sig     = estado;
        pin_reg_sig    = pin_reg;
        cuenta_sig     = cuenta;
        intentos_sig   = intentos;
        intentos_nuevo = intentos + 3'd1;
        monto_sig      = monto_reg;
        tipo_sig       = tipo_reg;
        balance_sig    = balance;
        cargado_sig    = cargado;
        adv_sig        = advertencia;
        act_sig        = 1'b0;
        ent_sig        = 1'b0;
        fondos_sig     = 1'b0;
        inc_sig        = 1'b0;

        case (estado)
            ST_ESPERA_TARJETA: begin
                if (TARJETA_RECIBIDA) begin
                    estado_sig   = ST_ESPERA_PIN;
                    cuenta_sig   = 2'd0;
                    intentos_sig = 3'd0;
                    adv_sig      = 1'b0;
                end
            end
            ST_ESPERA_PIN: begin
                if (digito_flanco) begin
                    pin_reg_sig = {pin_reg[7:0], DIGITO};
                    if (cuenta == 2'd3) begin
                        cuenta_sig = 2'd0;
                        if ({pin_reg, DIGITO} == PIN_CORRECTO) begin
                            estado_sig   = ST_ESPERA_MONTO;
                            intentos_sig = 3'd0;
                            adv_sig      = 1'b0;
                        end else begin
                            intentos_sig = intentos_nuevo;
                            inc_sig      = 1'b1;
                            if (intentos_nuevo == MAX_I - 3'd1) begin
                                adv_sig = 1'b1;
                            end
                            if (intentos_nuevo == MAX_I) begin
                                estado_sig = ST_BLOQUEO;
                                adv_sig    = 1'b0;
                            end
                        end
                    end else begin
                        cuenta_sig = cuenta + 2'd1;
                    end
                end
            end
            ST_ESPERA_MONTO: begin
                if (monto_flanco) begin
                    monto_sig  = MONTO;
                    tipo_sig   = TIPO_TRANS;
                    estado_sig = ST_TRANSACCION;
                end
            end
            ST_TRANSACCION: begin
                estado_sig = ST_ESPERA_TARJETA;
                if (tipo_reg == TIPO_DEPOSITO) begin
                    balance_sig = suma_deposito;
                    act_sig     = 1'b1;
                end else if (monto_ext <= balance) begin
                    balance_sig = balance - monto_ext;
                    act_sig     = 1'b1;
                    ent_sig     = 1'b1;
                end else begin
                    fondos_sig = 1'b1;
                end
            end
            ST_BLOQUEO: begin
                // Locked: everything except RESET is ignored.
            end
            default: estado_sig = ST_ESPERA_TARJETA;
        endcase

        // The starting balance is captured once, on the first edge after reset.
        if (!cargado) begin
            balance_sig = BALANCE_INICIAL;
            cargado_sig = 1'b1;
        end
    end

    // State, datapath and registered-output flops.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            estado      <= ST_ESPERA_TARJETA;
            pin_reg     <= '0;
            cuenta      <= '0;
            intentos    <= '0;
            monto_reg   <= '0;
            tipo_reg    <= TIPO_DEPOSITO;
            balance     <= '0;
            cargado     <= 1'b0;
            advertencia <= 1'b0;
            act         <= 1'b0;
            entregar    <= 1'b0;
            fondos      <= 1'b0;
            pin_inc     <= 1'b0;
        end else begin
            estado      <= estado_sig;
            pin_reg     <= pin_reg_sig;
            cuenta      <= cuenta_sig;
            intentos    <= intentos_sig;
            monto_reg   <= monto_sig;
            tipo_reg    <= tipo_sig;
            balance     <= balance_sig;
            cargado     <= cargado_sig;
            advertencia <= adv_sig;
            act         <= act_sig;
            entregar    <= ent_sig;
            fondos      <= fondos_sig;
            pin_inc     <= inc_sig;
        end
    end

    assign BALANCE              = balance;
    assign BALANCE_ACTUALIZADO  = act;
    assign ENTREGAR_DINERO      = entregar;
    assign FONDOS_INSUFICIENTES = fondos;
    assign PIN_INCORRECTO       = pin_inc;
    assign ADVERTENCIA          = advertencia;
    assign BLOQUEO              = (estado == ST_BLOQUEO);

endmodule

// File: tb/tb_cajero_ctrl.sv
// Bench for cajero_ctrl: directed scenarios plus randomized sessions,
// compared against a session-level model of balance, attempts and lock.
// Honours BALANCE_SAT_EN the same way the design does.
module tb_cajero_ctrl;

    localparam int MAX_INTENTOS = 3;
    localparam logic [15:0] PIN = 16'h3566;

    logic        CLK;
    logic        RESET;
    logic        TARJETA_RECIBIDA;
    logic        DIGITO_STB;
    logic [3:0]  DIGITO;
    logic [15:0] PIN_CORRECTO;
    logic [63:0] BALANCE_INICIAL;
    logic        TIPO_TRANS;
    logic        MONTO_STB;
    logic [31:0] MONTO;
    logic [63:0] BALANCE;
    logic        BALANCE_ACTUALIZADO;
    logic        ENTREGAR_DINERO;
    logic        FONDOS_INSUFICIENTES;
    logic        PIN_INCORRECTO;
    logic        ADVERTENCIA;
    logic        BLOQUEO;

    cajero_ctrl #(.MAX_INTENTOS(MAX_INTENTOS)) dut (
        .CLK                 (CLK),
        .RESET               (RESET),
        .TARJETA_RECIBIDA    (TARJETA_RECIBIDA),
        .DIGITO_STB          (DIGITO_STB),
        .DIGITO              (DIGITO),
        .PIN_CORRECTO        (PIN_CORRECTO),
        .BALANCE_INICIAL     (BALANCE_INICIAL),
        .TIPO_TRANS          (TIPO_TRANS),
        .MONTO_STB           (MONTO_STB),
        .MONTO               (MONTO),
        .BALANCE             (BALANCE),
        .BALANCE_ACTUALIZADO (BALANCE_ACTUALIZADO),
        .ENTREGAR_DINERO     (ENTREGAR_DINERO),
        .FONDOS_INSUFICIENTES(FONDOS_INSUFICIENTES),
        .PIN_INCORRECTO      (PIN_INCORRECTO),
        .ADVERTENCIA         (ADVERTENCIA),
        .BLOQUEO             (BLOQUEO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    // Session-level reference model.
    logic [63:0] m_bal;
    int          m_attempts;
    bit          m_adv;
    bit          m_locked;
    bit          m_in_amount;

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input bit e_act, input bit e_ent, input bit e_fon);
        check({tag, "_balance"}, BALANCE, m_bal);
        check({tag, "_actualizado"}, BALANCE_ACTUALIZADO, e_act);
        check({tag, "_entregar"}, ENTREGAR_DINERO, e_ent);
        check({tag, "_fondos"}, FONDOS_INSUFICIENTES, e_fon);
    endtask

    task automatic do_reset(input logic [63:0] init);
        RESET = 1'b1;
        BALANCE_INICIAL = init;
        tick();
        m_bal = 64'd0;
        check_outs("in_reset", 1'b0, 1'b0, 1'b0);
        check("in_reset_bloqueo", BLOQUEO, 1'b0);
        check("in_reset_adv", ADVERTENCIA, 1'b0);
        check("in_reset_pin_inc", PIN_INCORRECTO, 1'b0);
        RESET = 1'b0;
        tick();
        m_bal = init;
        m_attempts = 0;
        m_adv = 1'b0;
        m_locked = 1'b0;
        m_in_amount = 1'b0;
        check("load_balance", BALANCE, m_bal);
    endtask

    task automatic card();
        TARJETA_RECIBIDA = 1'b1;
        tick();
        TARJETA_RECIBIDA = 1'b0;
        if (!m_locked) begin
            m_attempts = 0;
            m_adv = 1'b0;
        end
        check("card_adv", ADVERTENCIA, m_adv);
        check("card_bloqueo", BLOQUEO, m_locked);
    endtask

    // One of the first three digits; DIGITO is scrambled while the strobe
    // stays high, which must not matter.
    task automatic digit(input logic [3:0] d, input int hold);
        DIGITO = d;
        DIGITO_STB = 1'b1;
        repeat (hold) begin
            tick();
            DIGITO = 4'($urandom);
        end
        DIGITO_STB = 1'b0;
        tick();
    endtask

    // 4th digit: the verdict is registered on this edge.
    task automatic verdict(input logic [15:0] pin);
        bit e_inc;
        DIGITO = pin[3:0];
        DIGITO_STB = 1'b1;
        MONTO_STB = 1'($urandom);
        tick();
        e_inc = 1'b0;
        if (!m_locked) begin
            if (pin == PIN_CORRECTO) begin
                m_attempts = 0;
                m_adv = 1'b0;
                m_in_amount = 1'b1;
            end else begin
                m_attempts++;
                e_inc = 1'b1;
                if (m_attempts == MAX_INTENTOS - 1) m_adv = 1'b1;
                if (m_attempts == MAX_INTENTOS) begin
                    m_locked = 1'b1;
                    m_adv = 1'b0;
                end
            end
        end
        check("pin_incorrecto", PIN_INCORRECTO, e_inc);
        check("pin_adv", ADVERTENCIA, m_adv);
        check("pin_bloqueo", BLOQUEO, m_locked);
        DIGITO_STB = 1'b0;
        MONTO_STB = 1'b0;
        tick();
        check("pin_incorrecto_end", PIN_INCORRECTO, 1'b0);
    endtask

    task automatic enter_pin(input logic [15:0] pin, input int hold);
        digit(pin[15:12], hold);
        digit(pin[11:8], hold);
        digit(pin[7:4], hold);
        verdict(pin);
    endtask

    task automatic do_amount(input logic tipo, input logic [31:0] monto);
        logic [64:0] s;
        bit e_act, e_ent, e_fon;
        MONTO = monto;
        TIPO_TRANS = tipo;
        MONTO_STB = 1'b1;
        if (m_in_amount) DIGITO_STB = 1'($urandom);
        tick();
        MONTO = $urandom;
        TIPO_TRANS = 1'($urandom);
        check_outs("amt_latch", 1'b0, 1'b0, 1'b0);
        tick();
        e_act = 1'b0;
        e_ent = 1'b0;
        e_fon = 1'b0;
        if (m_in_amount) begin
            if (tipo == 1'b0) begin
                s = {1'b0, m_bal} + {33'd0, monto};
`ifdef BALANCE_SAT_EN
                m_bal = s[64] ? 64'hFFFF_FFFF_FFFF_FFFF : s[63:0];
`else
                m_bal = s[63:0];
`endif
                e_act = 1'b1;
            end else if ({32'd0, monto} <= m_bal) begin
                m_bal = m_bal - {32'd0, monto};
                e_act = 1'b1;
                e_ent = 1'b1;
            end else begin
                e_fon = 1'b1;
            end
        end
        m_in_amount = 1'b0;
        check_outs("amt_result", e_act, e_ent, e_fon);
        MONTO_STB = 1'b0;
        DIGITO_STB = 1'b0;
        tick();
        check_outs("amt_after", 1'b0, 1'b0, 1'b0);
    endtask

    task automatic session(input logic [15:0] pin, input logic tipo, input logic [31:0] monto);
        card();
        enter_pin(pin, 1);
        do_amount(tipo, monto);
    endtask

    function automatic logic [15:0] wrong_pin();
        logic [15:0] p;
        do p = 16'($urandom); while (p == PIN_CORRECTO);
        return p;
    endfunction

    initial begin
        TARJETA_RECIBIDA = 1'b0;
        DIGITO_STB = 1'b0;
        DIGITO = 4'd0;
        PIN_CORRECTO = PIN;
        BALANCE_INICIAL = 64'd0;
        TIPO_TRANS = 1'b0;
        MONTO_STB = 1'b0;
        MONTO = 32'd0;
        RESET = 1'b1;
        m_bal = 64'd0;
        m_attempts = 0;
        m_adv = 1'b0;
        m_locked = 1'b0;
        m_in_amount = 1'b0;

        do_reset(64'd10000);
        BALANCE_INICIAL = 64'd5;
        tick();
        tick();
        check("inicial_ignored", BALANCE, 64'd10000);

        session(PIN, 1'b0, 32'd10000);
        check("deposit_20000", BALANCE, 64'd20000);
        session(PIN, 1'b1, 32'd7000);
        check("withdraw_13000", BALANCE, 64'd13000);

        card();
        enter_pin(16'h3561, 1);
        enter_pin(16'h1111, 1);
        check("warn_after_2", ADVERTENCIA, 1'b1);
        enter_pin(16'h1534, 1);
        check("locked_after_3", BLOQUEO, 1'b1);
        session(PIN, 1'b0, 32'd500);
        check("locked_balance", BALANCE, 64'd13000);

        do_reset(64'd10000);
        session(PIN, 1'b0, 32'd10000);
        session(PIN, 1'b1, 32'd900000);
        check("insufficient_keep", BALANCE, 64'd20000);
        session(PIN, 1'b1, 32'd20000);
        check("withdraw_all", BALANCE, 64'd0);
        session(PIN, 1'b1, 32'd1);
        session(PIN, 1'b0, 32'd20000);

        // Held strobe counts once; a card mid-PIN does not restart the session.
        card();
        enter_pin(PIN, 3);
        do_amount(1'b0, 32'd42);
        card();
        digit(4'h3, 1);
        digit(4'h5, 1);
        TARJETA_RECIBIDA = 1'b1;
        tick();
        TARJETA_RECIBIDA = 1'b0;
        digit(4'h6, 1);
        verdict(PIN);
        do_amount(1'b1, 32'd1234);

        // Amount strobe with no session open is ignored.
        do_amount(1'b0, 32'd777);

        for (int it = 0; it < 24; it++) begin
            int nwrong;
            logic t;
            logic [31:0] mt;
            card();
            nwrong = ($urandom_range(0, 7) == 0) ? MAX_INTENTOS : $urandom_range(0, MAX_INTENTOS - 1);
            for (int w = 0; w < nwrong; w++) enter_pin(wrong_pin(), 1);
            if (!m_locked) enter_pin(PIN, $urandom_range(1, 3));
            t = 1'($urandom);
            mt = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 30000)) : $urandom;
            do_amount(t, mt);
            if (m_locked) do_reset({$urandom, $urandom} >> 2);
        end

        // Reset in the middle of a transaction aborts it.
        card();
        enter_pin(PIN, 1);
        MONTO = 32'd5;
        TIPO_TRANS = 1'b0;
        MONTO_STB = 1'b1;
        tick();
        MONTO_STB = 1'b0;
        do_reset(64'd31337);

        do_reset(64'hFFFF_FFFF_FFFF_FFCE);
        session(PIN, 1'b0, 32'd100);
`ifdef BALANCE_SAT_EN
        check("deposit_saturate", BALANCE, 64'hFFFF_FFFF_FFFF_FFFF);
`else
        check("deposit_wrap", BALANCE, 64'd50);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
